spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//  SPI responder (mode 0: CPOL=0, CPHA=0), the far end of spi_master. Oversamples serial_clock,
//  chip_select and serial_in in the system clock domain, decodes one rw/address/data frame per
//  chip-select assertion, and drives a simple register-file port. This is synthesizable and
//  replaces spi_slave_sim_model in the system.
// PARAMETERS
//  DATA_WIDTH      16  data bits per frame
//  ADDRESS_WIDTH   15  address bits per frame
// PORTS
//  clock           in   1              system clock; single clock domain
//  reset_n         in   1              asynchronous, active-low reset
//  serial_clock    in   1              SCLK from master (asynchronous)
//  chip_select     in   1              active-low slave select from master
//  serial_in       in   1              MOSI
//  serial_out      out  1              MISO
//  write_enable    out  1              1-cycle write strobe
//  write_address   out  ADDRESS_WIDTH  write address; valid while write_enable=1
//  write_data      out  DATA_WIDTH     write data; valid while write_enable=1
//  read_enable     out  1              1-cycle read request
//  read_address    out  ADDRESS_WIDTH  read address; valid while read_enable=1
//  read_data       in   DATA_WIDTH     sampled exactly 1 clock after read_enable
//  busy            out  1              1 while the synchronized chip_select is low
//  frame_error     out  1              1-cycle pulse when a frame aborts early
// BEHAVIOUR
//  Input synchronization and timing
//  - serial_clock, chip_select, serial_in: 2-flop synchronizers, then a 3rd flop for edge detect.
//  - Requirement on the master: SCLK high and low phases each >= 4 clock cycles
//    (spi_master divider >= 2).
//  Frame format (MSB first, 1+ADDRESS_WIDTH+DATA_WIDTH bits)
//  - bit 0 = rw: 1 = read, 0 = write.
//  - then address[ADDRESS_WIDTH-1:0], then data[DATA_WIDTH-1:0].
//  - MOSI is sampled on the synchronized SCLK rising edge.
//  - MISO is updated on the synchronized SCLK falling edge.
//  FSM states: IDLE, COMMAND, ADDRESS, DATA, DONE.
//  - IDLE -> COMMAND on chip_select falling edge; bit counter cleared; serial_out=0.
//  - COMMAND: 1st rising edge latches rw -> ADDRESS.
//  - ADDRESS: shift ADDRESS_WIDTH bits. On the last one:
//      read:  pulse read_enable with read_address; load read_data into the TX shift register
//             in the next cycle.
//      then -> DATA.
//  - DATA:
//      read:  each falling edge drives the next TX bit on serial_out, MSB first. The first
//             falling edge after the address drives data[DATA_WIDTH-1].
//      write: shift DATA_WIDTH bits; after the last rising edge, pulse write_enable for one
//             cycle with address and data -> DONE.
//      read:  -> DONE after the DATA_WIDTH-th rising edge.
//  - DONE: further SCLK edges are ignored; serial_out=0; leave on chip_select rising -> IDLE.
//  - chip_select rising in COMMAND, ADDRESS or DATA: abort -> IDLE, pulse frame_error,
//    no write_enable.
//  - A read whose read_enable already fired is not retracted on abort.
//  - chip_select rising and the final SCLK edge in the same cycle: the edge is processed first,
//    so the frame completes and frame_error=0.
//  - serial_out = 0 whenever chip_select is high or the state is not a read DATA phase.
//  Reset values
//  - All outputs 0 (serial_out, write_enable, read_enable, busy, frame_error, addresses, data).
//  - FSM in IDLE; synchronizer flops reset so that chip_select=1 and SCLK=0.
//  - Reset mid-frame: immediate return to IDLE, no strobes. The remainder of that frame is
//    ignored until the next chip_select falling edge.
//  Latency
//  - write_enable: 3-4 clocks after the last synchronized SCLK rise.
//  - read_enable: 3-4 clocks after the last address-bit SCLK rise.
// STRUCTURE
//  spi_pkg: state enum typedef, CPOL/CPHA mode constants, rw encoding constants
//  (SPI_READ=1, SPI_WRITE=0).
//  Sub-module spi_input_synchronizer:
//  - 3-flop synchronizer with rise/fall pulse outputs.
//  - Instanced for serial_clock and chip_select; serial_in uses the data path only.
//  Main module: FSM, bit counter sized $clog2(1+ADDRESS_WIDTH+DATA_WIDTH), RX and TX shift
//  registers.
// TESTING (bench: spi_master divider=3 plus a 2^15 x 16 register array model)
//  1. Write rw=0, addr 15'h1111, data 16'hA5C3 -> one write_enable pulse with
//     write_address=15'h1111, write_data=16'hA5C3; frame_error=0.
//  2. Read rw=1, addr 15'h1111 -> read_enable pulse with read_address=15'h1111;
//     master read_data=16'hA5C3.
//  3. Write 16'h0001 to 15'h0000, then 16'h8000 to 15'h7FFF, then read both back
//     -> boundary bits are returned intact.
//  4. Deassert chip_select after 10 SCLK cycles of a write
//     -> frame_error pulse, no write_enable; the next full write succeeds.
//  5. Assert reset_n=0 for 100 ns mid-read -> all outputs 0 and IDLE; a later read of
//     15'h1111 returns 16'hA5C3.
//  6. Back-to-back frames with chip_select high for 2 SCLK periods
//     -> exactly one strobe per frame, busy low between frames.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: FSM states, bus mode, rw encoding.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMMAND,
        ST_ADDRESS,
        ST_DATA,
        ST_DONE
    } spi_state_e;

    // Mode 0: SCLK idles low, data sampled on the leading (rising) edge.
    localparam logic SPI_CPOL  = 1'b0;
    localparam logic SPI_CPHA  = 1'b0;

    // First frame bit.
    localparam logic SPI_READ  = 1'b1;
    localparam logic SPI_WRITE = 1'b0;

endpackage

// File: rtl/spi_input_synchronizer.sv
// Two-flop synchronizer for an asynchronous input, plus a third flop used to
// produce single-cycle rise/fall pulses of the synchronized level.
module spi_input_synchronizer #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [2:0] pipe_q;
    logic [2:0] pipe_d;

    // Shift the raw input into the synchronizer chain.
    always_comb begin
        pipe_d = {pipe_q[1:0], async_in};
    end

    // Synchronizer / edge-detect register chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q <= {3{RESET_VALUE}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign sync_out = pipe_q[1];
    assign rise     = pipe_q[1] & ~pipe_q[2];
    assign fall     = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder. Oversamples SCLK/CS/MOSI in the system clock domain,
// decodes one rw/address/data frame per chip-select assertion and drives a
// simple register-file port (write strobe, read request with 1-cycle return).
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_WIDTH = 15
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     serial_clock,
    input  logic                     chip_select,
    input  logic                     serial_in,
    output logic                     serial_out,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     read_enable,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0]    read_data,
    output logic                     busy,
    output logic                     frame_error
);

    localparam int unsigned FRAME_BITS = 1 + ADDRESS_WIDTH + DATA_WIDTH;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
    // Counter value at the last address bit and at the last data bit.
    localparam logic [CNT_W-1:0] LAST_ADDR_CNT = CNT_W'(ADDRESS_WIDTH);
    localparam logic [CNT_W-1:0] LAST_DATA_CNT = CNT_W'(ADDRESS_WIDTH + DATA_WIDTH);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;
    logic sample_edge, shift_edge;

    spi_input_synchronizer #(.RESET_VALUE(SPI_CPOL)) u_sync_sclk (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (serial_clock),
        .sync_out (sclk_level_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_input_synchronizer #(.RESET_VALUE(1'b1)) u_sync_cs (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (chip_select),
        .sync_out (cs_sync),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    spi_input_synchronizer #(.RESET_VALUE(1'b0)) u_sync_mosi (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (serial_in),
        .sync_out (mosi_sync),
        .rise     (mosi_rise_unused),
        .fall     (mosi_fall_unused)
    );

    assign sample_edge = (SPI_CPOL == SPI_CPHA) ? sclk_rise : sclk_fall;
    assign shift_edge  = (SPI_CPOL == SPI_CPHA) ? sclk_fall : sclk_rise;

    spi_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     rw_q, rw_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    rx_q, rx_d;
    logic [DATA_WIDTH-1:0]    tx_q, tx_d;
    logic                     serial_out_q, serial_out_d;
    logic                     write_enable_q, write_enable_d;
    logic [ADDRESS_WIDTH-1:0] write_address_q, write_address_d;
    logic [DATA_WIDTH-1:0]    write_data_q, write_data_d;
    logic                     read_enable_q, read_enable_d;
    logic [ADDRESS_WIDTH-1:0] read_address_q, read_address_d;
    logic                     frame_error_q, frame_error_d;
    logic [1:0]               warm_q, warm_d;
    logic                     armed_q, armed_d;

    // Next-state, shift registers and strobes for one frame.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rw_d            = rw_q;
        addr_d          = addr_q;
        rx_d            = rx_q;
        tx_d            = tx_q;
        serial_out_d    = serial_out_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        read_enable_d   = 1'b0;
        read_address_d  = read_address_q;
        frame_error_d   = 1'b0;
        armed_d         = armed_q;

        // After reset the CS synchronizer holds its reset value for two
        // clocks; only accept a new frame once a real high level has been
        // seen, so a frame interrupted by reset is ignored to its end.
        warm_d = {warm_q[0], 1'b1};
        if (warm_q[1] && cs_sync) begin
            armed_d = 1'b1;
        end

        // Read data returns one clock after the request.
        if (read_enable_q) begin
            tx_d = read_data;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d = ST_COMMAND;
                    cnt_d   = '0;
                end
            end
            ST_COMMAND: begin
                if (sample_edge) begin
                    rw_d    = mosi_sync;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_ADDRESS;
                end
            end
            ST_ADDRESS: begin
                if (sample_edge) begin
                    addr_d = {addr_q[ADDRESS_WIDTH-2:0], mosi_sync};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR_CNT) begin
                        if (rw_q == SPI_READ) begin
                            read_enable_d  = 1'b1;
                            read_address_d = addr_d;
                        end
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sample_edge) begin
                    rx_d  = {rx_q[DATA_WIDTH-2:0], mosi_sync};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_DATA_CNT) begin
                        if (rw_q == SPI_WRITE) begin
                            write_enable_d  = 1'b1;
                            write_address_d = addr_q;
                            write_data_d    = rx_d;
                        end
                        state_d = ST_DONE;
                    end
                end
                if (shift_edge && (rw_q == SPI_READ)) begin
                    serial_out_d = tx_q[DATA_WIDTH-1];
                    tx_d         = {tx_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // CS release is applied after any SCLK edge of the same cycle, so a
        // frame whose last edge coincides with CS rising still completes.
        if (cs_rise) begin
            if ((state_d == ST_COMMAND) || (state_d == ST_ADDRESS) || (state_d == ST_DATA)) begin
                frame_error_d = 1'b1;
            end
            state_d = ST_IDLE;
        end

        if (!((state_d == ST_DATA) && (rw_d == SPI_READ))) begin
            serial_out_d = 1'b0;
        end
    end

    // Frame state and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            rw_q            <= SPI_WRITE;
            addr_q          <= '0;
            rx_q            <= '0;
            tx_q            <= '0;
            serial_out_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_data_q    <= '0;
            read_enable_q   <= 1'b0;
            read_address_q  <= '0;
            frame_error_q   <= 1'b0;
            warm_q          <= '0;
            armed_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rw_q            <= rw_d;
            addr_q          <= addr_d;
            rx_q            <= rx_d;
            tx_q            <= tx_d;
            serial_out_q    <= serial_out_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            read_enable_q   <= read_enable_d;
            read_address_q  <= read_address_d;
            frame_error_q   <= frame_error_d;
            warm_q          <= warm_d;
            armed_q         <= armed_d;
        end
    end

    assign serial_out    = serial_out_q;
    assign write_enable  = write_enable_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign read_enable   = read_enable_q;
    assign read_address  = read_address_q;
    assign frame_error   = frame_error_q;
    assign busy          = ~cs_sync;

endmodule
